// File: rtl/vend_pkg.sv
// vend_pkg: definitions shared by the vending-machine front end and the vending FSM.
//  - channel index constants (CH_WATER..CH_CANCEL) and NUM_CH
//  - arbiter state encoding (IDLE / ISSUE / GAP)
//  - arbitration priority order and a fixed-priority picker
package vend_pkg;

  localparam int NUM_CH = 6;

  typedef logic [2:0] ch_idx_t;

  localparam ch_idx_t CH_WATER  = 3'd0;
  localparam ch_idx_t CH_COKE   = 3'd1;
  localparam ch_idx_t CH_COFFEE = 3'd2;
  localparam ch_idx_t CH_COIN5  = 3'd3;
  localparam ch_idx_t CH_COIN10 = 3'd4;
  localparam ch_idx_t CH_CANCEL = 3'd5;

  // Product-selection channels; a cancel throws these away but keeps coins.
  localparam logic [NUM_CH-1:0] SEL_MASK = 6'b000111;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

  // Highest priority first.
  localparam ch_idx_t PRIO_ORDER [NUM_CH] = '{
    CH_CANCEL, CH_COIN10, CH_COIN5, CH_COFFEE, CH_COKE, CH_WATER
  };

  // One-hot grant of the highest-priority requester, zero when nothing requests.
  function automatic logic [NUM_CH-1:0] pick_highest(input logic [NUM_CH-1:0] req);
    logic [NUM_CH-1:0] grant;
    grant = {NUM_CH{1'b0}};
    // Walk from lowest to highest priority so the last hit is the winner.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[PRIO_ORDER[i]]) begin
        grant = {NUM_CH{1'b0}};
        grant[PRIO_ORDER[i]] = 1'b1;
      end else begin
        grant = grant;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/vend_debounce.sv
// vend_debounce: one input channel of the front end.
//  raw -> 2-flop synchroniser -> debounce counter -> stable level.
//  The stable level follows the synchronised input only after DEBOUNCE_CYCLES
//  consecutive samples that disagree with it; rise pulses for one cycle on the
//  clock edge at which the stable level goes 0 -> 1.
// Ports:
//  clk   in  system clock
//  rst_n in  asynchronous active-low reset
//  raw   in  asynchronous, bouncy input
//  rise  out one-cycle pulse on an accepted rising edge
import vend_pkg::*;

module vend_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // The edge that would bring the count to DEBOUNCE_CYCLES is the accepting edge.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_r;
  logic          stable_r;
  logic [CW-1:0] cnt_r;
  logic          rise_r;

  // Synchroniser, debounce counter, stable level and rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r   <= 2'b00;
      stable_r <= 1'b0;
      cnt_r    <= CNT_ZERO;
      rise_r   <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], raw};
      rise_r <= 1'b0;
      if (sync_r[1] == stable_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= sync_r[1];
        cnt_r    <= CNT_ZERO;
        rise_r   <= sync_r[1];
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/vend_input_cond.sv
// vend_input_cond: front-end conditioner for the vending-machine controller.
//  Debounces six raw panel/coin inputs, latches each accepted rising edge as a
//  pending event and issues pending events one at a time as registered
//  single-cycle pulses, separated by GAP_CYCLES all-zero cycles.
// Ports:
//  clk, rst_n          clock, asynchronous active-low reset
//  raw_*               asynchronous bouncy inputs (coin5, coin10, sel_water/coke/coffee, cancel)
//  hold                downstream busy; pending events wait while high
//  clr_lost            synchronous clear of evt_lost
//  coin5 .. cancel     one-cycle event pulses, at most one high per cycle
//  evt_lost            sticky flag: an accepted edge hit an already-pending channel
import vend_pkg::*;

module vend_input_cond #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_coin5,
  input  logic raw_coin10,
  input  logic raw_sel_water,
  input  logic raw_sel_coke,
  input  logic raw_sel_coffee,
  input  logic raw_cancel,
  input  logic hold,
  input  logic clr_lost,
  output logic coin5,
  output logic coin10,
  output logic sel_water,
  output logic sel_coke,
  output logic sel_coffee,
  output logic cancel,
  output logic evt_lost
);

  localparam int GW = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  // The IDLE cycle that precedes the next issue is the last guard cycle, so the
  // GAP state itself only has to cover GAP_CYCLES-1 cycles.
  localparam int GAP_LOAD_INT = (GAP_CYCLES > 1) ? (GAP_CYCLES - 1) : 0;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_LOAD_INT);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};
  localparam logic [NUM_CH-1:0] CH_NONE = {NUM_CH{1'b0}};

  logic [NUM_CH-1:0] raw_vec_s;
  logic [NUM_CH-1:0] rise_s;

  logic [NUM_CH-1:0] pending_r;
  logic [NUM_CH-1:0] evt_out_r;
  logic              lost_r;
  arb_state_e        state_r;
  logic [GW-1:0]     gap_cnt_r;

  logic [NUM_CH-1:0] grant_s;
  logic              issue_s;
  logic [NUM_CH-1:0] clear_s;
  logic [NUM_CH-1:0] kept_s;
  logic [NUM_CH-1:0] pending_nxt_s;
  logic              lost_hit_s;
  arb_state_e        state_nxt_s;
  logic [GW-1:0]     gap_cnt_nxt_s;
  logic [NUM_CH-1:0] evt_nxt_s;

  assign raw_vec_s[CH_WATER]  = raw_sel_water;
  assign raw_vec_s[CH_COKE]   = raw_sel_coke;
  assign raw_vec_s[CH_COFFEE] = raw_sel_coffee;
  assign raw_vec_s[CH_COIN5]  = raw_coin5;
  assign raw_vec_s[CH_COIN10] = raw_coin10;
  assign raw_vec_s[CH_CANCEL] = raw_cancel;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    vend_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_vec_s[g]),
      .rise (rise_s[g])
    );
  end

  // Arbitration choice and pending-flag bookkeeping.
  always_comb begin
    grant_s = pick_highest(pending_r);
    issue_s = (state_r == ARB_IDLE) && !hold && (pending_r != CH_NONE);
    clear_s = CH_NONE;
    if (issue_s) begin
      clear_s = grant_s;
      if (grant_s[CH_CANCEL]) begin
        clear_s = grant_s | SEL_MASK;
      end else begin
        clear_s = grant_s;
      end
    end else begin
      clear_s = CH_NONE;
    end
    kept_s        = pending_r & ~clear_s;
    // A new edge always re-arms the channel; it is only "lost" when the
    // channel was still waiting from an earlier edge.
    pending_nxt_s = kept_s | rise_s;
    lost_hit_s    = ((kept_s & rise_s) != CH_NONE);
  end

  // Arbiter next state, guard counter and next pulse vector.
  always_comb begin
    state_nxt_s   = state_r;
    gap_cnt_nxt_s = gap_cnt_r;
    evt_nxt_s     = CH_NONE;
    case (state_r)
      ARB_IDLE: begin
        if (issue_s) begin
          state_nxt_s = ARB_ISSUE;
          evt_nxt_s   = grant_s;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        if (GAP_CYCLES > 1) begin
          state_nxt_s   = ARB_GAP;
          gap_cnt_nxt_s = GAP_LOAD;
        end else begin
          state_nxt_s   = ARB_IDLE;
          gap_cnt_nxt_s = GAP_ZERO;
        end
      end
      ARB_GAP: begin
        if (gap_cnt_r <= GAP_ONE) begin
          state_nxt_s   = ARB_IDLE;
          gap_cnt_nxt_s = GAP_ZERO;
        end else begin
          state_nxt_s   = ARB_GAP;
          gap_cnt_nxt_s = gap_cnt_r - GAP_ONE;
        end
      end
      default: begin
        state_nxt_s   = ARB_IDLE;
        gap_cnt_nxt_s = GAP_ZERO;
      end
    endcase
  end

  // Arbiter state, pending flags, registered pulses and sticky lost flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ARB_IDLE;
      gap_cnt_r <= GAP_ZERO;
      pending_r <= CH_NONE;
      evt_out_r <= CH_NONE;
      lost_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
      pending_r <= pending_nxt_s;
      evt_out_r <= evt_nxt_s;
      if (lost_hit_s) begin
        lost_r <= 1'b1;
      end else if (clr_lost) begin
        lost_r <= 1'b0;
      end else begin
        lost_r <= lost_r;
      end
    end
  end

  assign sel_water  = evt_out_r[CH_WATER];
  assign sel_coke   = evt_out_r[CH_COKE];
  assign sel_coffee = evt_out_r[CH_COFFEE];
  assign coin5      = evt_out_r[CH_COIN5];
  assign coin10     = evt_out_r[CH_COIN10];
  assign cancel     = evt_out_r[CH_CANCEL];
  assign evt_lost   = lost_r;

endmodule

// File: tb/tb_vend_input_cond.sv
// Self-checking bench for vend_input_cond (DEBOUNCE_CYCLES=4, GAP_CYCLES=2).
// Stimulus pushes the expected pulse (channel, clock-edge number) into a queue;
// a negedge monitor pops and compares whenever any event output is high.
module tb_vend_input_cond;

  localparam int D = 4;
  localparam int G = 2;
  localparam int LAT = D + 4;

  // Bit positions of the monitor's output vector.
  localparam int B_WATER  = 0;
  localparam int B_COKE   = 1;
  localparam int B_COFFEE = 2;
  localparam int B_COIN5  = 3;
  localparam int B_COIN10 = 4;
  localparam int B_CANCEL = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic raw_coin5, raw_coin10, raw_sel_water, raw_sel_coke, raw_sel_coffee, raw_cancel;
  logic hold, clr_lost;
  logic coin5, coin10, sel_water, sel_coke, sel_coffee, cancel, evt_lost;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  vend_input_cond #(
    .DEBOUNCE_CYCLES(D),
    .GAP_CYCLES(G)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .raw_coin5     (raw_coin5),
    .raw_coin10    (raw_coin10),
    .raw_sel_water (raw_sel_water),
    .raw_sel_coke  (raw_sel_coke),
    .raw_sel_coffee(raw_sel_coffee),
    .raw_cancel    (raw_cancel),
    .hold          (hold),
    .clr_lost      (clr_lost),
    .coin5         (coin5),
    .coin10        (coin10),
    .sel_water     (sel_water),
    .sel_coke      (sel_coke),
    .sel_coffee    (sel_coffee),
    .cancel        (cancel),
    .evt_lost      (evt_lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one-hot-or-zero check every cycle, scoreboard compare on any pulse.
  always @(negedge clk) begin
    logic [5:0] o;
    exp_t e;
    o = {cancel, coin10, coin5, sel_coffee, sel_coke, sel_water};
    tests_run++;
    if ((o & (o - 6'd1)) != 6'd0) begin
      tests_failed++;
      $display("FAIL onehot: outputs=%b at edge %0d, required at most one bit set", o, cyc);
    end
    if (o != 6'd0) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_pulse: outputs=%b at edge %0d, required 000000", o, cyc);
      end else begin
        e = exp_q.pop_front();
        if ((o != (6'd1 << e.ch)) || (cyc != e.cyc)) begin
          tests_failed++;
          $display("FAIL pulse: got outputs=%b at edge %0d, required %b at edge %0d",
                   o, cyc, 6'd1 << e.ch, e.cyc);
        end
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int ch, input int at);
    exp_t e;
    e.ch  = ch;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s: %0d expected pulse(s) never seen, required 0 outstanding", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic check_outs_zero(input string name);
    logic [5:0] o;
    o = {cancel, coin10, coin5, sel_coffee, sel_coke, sel_water};
    tests_run++;
    if (o !== 6'd0) begin
      tests_failed++;
      $display("FAIL %s: outputs=%b, required 000000", name, o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    raw_coin5 = 1'b0; raw_coin10 = 1'b0; raw_sel_water = 1'b0;
    raw_sel_coke = 1'b0; raw_sel_coffee = 1'b0; raw_cancel = 1'b0;
    hold = 1'b0; clr_lost = 1'b0;

    // Reset state.
    wait_edges(3);
    check_outs_zero("reset_outputs");
    check_bit("reset_evt_lost", evt_lost, 1'b0);
    rst_n = 1'b1;
    wait_edges(2);

    // 1: clean coin5 press, pulse D+4 edges after the first high sample.
    raw_coin5 = 1'b1;
    push_exp(B_COIN5, cyc + LAT);
    wait_edges(20);
    raw_coin5 = 1'b0;
    wait_edges(20);
    check_drained("t1_coin5");

    // 2: sel_coke glitches 3 cycles wide never get through.
    repeat (10) begin
      raw_sel_coke = 1'b1;
      wait_edges(3);
      raw_sel_coke = 1'b0;
      wait_edges(3);
    end
    wait_edges(15);
    check_drained("t2_glitch");
    check_bit("t2_evt_lost", evt_lost, 1'b0);

    // 3: simultaneous coin10 and sel_water: priority then a G-cycle gap.
    raw_coin10 = 1'b1;
    raw_sel_water = 1'b1;
    push_exp(B_COIN10, cyc + LAT);
    push_exp(B_WATER, cyc + LAT + G + 1);
    wait_edges(12);
    raw_coin10 = 1'b0;
    raw_sel_water = 1'b0;
    wait_edges(20);
    check_drained("t3_priority_gap");

    // 4: coin5 pending under hold; issued on the first edge that sees hold=0.
    hold = 1'b1;
    raw_coin5 = 1'b1;
    wait_edges(6);
    raw_coin5 = 1'b0;
    wait_edges(11);
    hold = 1'b0;
    push_exp(B_COIN5, cyc + 1);
    wait_edges(10);
    check_drained("t4_hold");

    // 5a: cancel wipes a pending sel_coffee.
    hold = 1'b1;
    raw_sel_coffee = 1'b1;
    wait_edges(6);
    raw_sel_coffee = 1'b0;
    wait_edges(6);
    raw_cancel = 1'b1;
    wait_edges(6);
    raw_cancel = 1'b0;
    wait_edges(10);
    hold = 1'b0;
    push_exp(B_CANCEL, cyc + 1);
    wait_edges(20);
    check_drained("t5_cancel_flush");

    // 5b: second coin5 press while the first is still pending sets evt_lost.
    hold = 1'b1;
    raw_coin5 = 1'b1;
    wait_edges(6);
    raw_coin5 = 1'b0;
    wait_edges(12);
    check_bit("t5_lost_after_first", evt_lost, 1'b0);
    raw_coin5 = 1'b1;
    wait_edges(6);
    raw_coin5 = 1'b0;
    wait_edges(12);
    check_bit("t5_lost_after_second", evt_lost, 1'b1);
    hold = 1'b0;
    push_exp(B_COIN5, cyc + 1);
    wait_edges(10);
    check_drained("t5_single_coin5");
    check_bit("t5_lost_sticky", evt_lost, 1'b1);
    clr_lost = 1'b1;
    wait_edges(1);
    clr_lost = 1'b0;
    check_bit("t5_lost_cleared", evt_lost, 1'b0);

    // 6: reset during GAP with coin10 pending; nothing comes out afterwards.
    raw_cancel = 1'b1;
    raw_coin10 = 1'b1;
    push_exp(B_CANCEL, cyc + LAT);
    wait_edges(LAT + 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs_zero("t6_reset_outputs");
    check_bit("t6_reset_evt_lost", evt_lost, 1'b0);
    raw_cancel = 1'b0;
    raw_coin10 = 1'b0;
    wait_edges(3);
    check_outs_zero("t6_in_reset");
    rst_n = 1'b1;
    wait_edges(30);
    check_drained("t6_no_pulse_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
